// File: rtl/lsq_dcache_port.sv
// Blocking, in-order data-cache port that sits behind the LSQ head.
// Each accepted entry becomes at most one cache access and exactly one tagged completion.
module lsq_dcache_port #(
  parameter int ENTRY_WIDTH = 81,
  parameter int TAG_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [ENTRY_WIDTH-1:0] data_i,
  output logic                   dc_req_valid_o,
  input  logic                   dc_req_ready_i,
  output logic                   dc_req_we_o,
  output logic [31:0]            dc_req_addr_o,
  output logic [31:0]            dc_req_wdata_o,
  output logic [3:0]             dc_req_wmask_o,
  input  logic                   dc_resp_valid_i,
  input  logic [31:0]            dc_resp_rdata_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [TAG_WIDTH-1:0]   wb_tag_o,
  output logic [31:0]            wb_data_o,
  output logic                   wb_exc_o
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB
  } state_e;

  // Entry field decode
  logic                 in_store;
  logic [1:0]           in_size;
  logic                 in_uns;
  logic [31:0]          in_addr;
  logic [31:0]          in_sdata;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 in_misaligned;
  logic [31:0]          in_wdata;
  logic [3:0]           in_wmask;
  logic                 unused_rsvd;

  assign in_store    = data_i[80];
  assign in_size     = data_i[79:78];
  assign in_uns      = data_i[77];
  assign in_addr     = data_i[76:45];
  assign in_sdata    = data_i[44:13];
  assign in_tag      = data_i[7 +: TAG_WIDTH];
  assign unused_rsvd = ^data_i[6:0];

  assign in_misaligned = (in_size == 2'b11) ||
                         ((in_size == SZ_HALF) && in_addr[0]) ||
                         ((in_size == SZ_WORD) && (in_addr[1:0] != 2'b00));

  always_comb begin
    in_wdata = in_sdata;
    case (in_size)
      SZ_BYTE: in_wdata = {4{in_sdata[7:0]}};
      SZ_HALF: in_wdata = {2{in_sdata[15:0]}};
      default: in_wdata = in_sdata;
    endcase
  end

  // Per-lane write enables and read-lane slicing
  logic [7:0] rd_byte [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign in_wmask[gi] = in_store &&
                            ((in_size == SZ_WORD) ||
                             ((in_size == SZ_HALF) && (in_addr[1] == LANE[1])) ||
                             ((in_size == SZ_BYTE) && (in_addr[1:0] == LANE)));
      assign rd_byte[gi] = dc_resp_rdata_i[8*gi +: 8];
    end
  endgenerate

  // Registered state
  state_e               state_q, state_d;
  logic                 store_q, store_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [1:0]           lo_addr_q, lo_addr_d;
  logic [31:0]          req_addr_q, req_addr_d;
  logic [31:0]          req_wdata_q, req_wdata_d;
  logic [3:0]           req_wmask_q, req_wmask_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic                 wb_exc_q, wb_exc_d;

  // Load result extraction from the returned word
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = rd_byte[lo_addr_q];
    ld_half = lo_addr_q[1] ? dc_resp_rdata_i[31:16] : dc_resp_rdata_i[15:0];
    ld_ext  = dc_resp_rdata_i;
    case (size_q)
      SZ_BYTE: ld_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = dc_resp_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lo_addr_q   <= 2'b00;
      req_addr_q  <= 32'b0;
      req_wdata_q <= 32'b0;
      req_wmask_q <= 4'b0;
      tag_q       <= '0;
      wb_data_q   <= 32'b0;
      wb_exc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lo_addr_q   <= lo_addr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      tag_q       <= tag_d;
      wb_data_q   <= wb_data_d;
      wb_exc_q    <= wb_exc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lo_addr_d   = lo_addr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    tag_d       = tag_q;
    wb_data_d   = wb_data_q;
    wb_exc_d    = wb_exc_q;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          store_d     = in_store;
          size_d      = in_size;
          uns_d       = in_uns;
          lo_addr_d   = in_addr[1:0];
          req_addr_d  = {in_addr[31:2], 2'b00};
          req_wdata_d = in_wdata;
          req_wmask_d = in_wmask;
          tag_d       = in_tag;
          wb_data_d   = 32'b0;
          wb_exc_d    = in_misaligned;
          // Misaligned or illegal-size entries complete without touching the cache
          state_d     = in_misaligned ? S_WB : S_REQ;
        end
      end
      S_REQ: begin
        if (dc_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dc_resp_valid_i) begin
          wb_data_d = store_q ? 32'b0 : ld_ext;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        if (wb_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_o        = (state_q == S_IDLE);
  assign dc_req_valid_o = (state_q == S_REQ);
  assign dc_req_we_o    = store_q;
  assign dc_req_addr_o  = req_addr_q;
  assign dc_req_wdata_o = req_wdata_q;
  assign dc_req_wmask_o = req_wmask_q;
  assign wb_valid_o     = (state_q == S_WB);
  assign wb_tag_o       = tag_q;
  assign wb_data_o      = wb_data_q;
  assign wb_exc_o       = wb_exc_q;

endmodule

// File: tb/tb_lsq_dcache_port.sv
// Scoreboard bench for lsq_dcache_port: expected requests/completions are queued at drive
// time and compared while the DUT presents them; a small cache model answers requests.
module tb_lsq_dcache_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [80:0] data_i;
  logic        dc_req_valid_o;
  logic        dc_req_ready_i;
  logic        dc_req_we_o;
  logic [31:0] dc_req_addr_o;
  logic [31:0] dc_req_wdata_o;
  logic [3:0]  dc_req_wmask_o;
  logic        dc_resp_valid_i;
  logic [31:0] dc_resp_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [5:0]  wb_tag_o;
  logic [31:0] wb_data_o;
  logic        wb_exc_o;

  always #5 clk = ~clk;

  lsq_dcache_port #(.ENTRY_WIDTH(81), .TAG_WIDTH(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .data_i         (data_i),
    .dc_req_valid_o (dc_req_valid_o),
    .dc_req_ready_i (dc_req_ready_i),
    .dc_req_we_o    (dc_req_we_o),
    .dc_req_addr_o  (dc_req_addr_o),
    .dc_req_wdata_o (dc_req_wdata_o),
    .dc_req_wmask_o (dc_req_wmask_o),
    .dc_resp_valid_i(dc_resp_valid_i),
    .dc_resp_rdata_i(dc_resp_rdata_i),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_tag_o       (wb_tag_o),
    .wb_data_o      (wb_data_o),
    .wb_exc_o       (wb_exc_o)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
    logic        exc;
  } wb_t;

  req_t reqq[$];
  wb_t  wbq[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] cache_rdata = 32'b0;
  int          resp_delay  = 1;
  logic        req_fire    = 1'b0;
  int          resp_cnt    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one entry
  function automatic void model(input logic st, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] rdata, input logic [5:0] tag,
                                output logic mis, output req_t r, output wb_t w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    r.we    = st;
    r.addr  = {a[31:2], 2'b00};
    r.wdata = (sz == 2'b00) ? {4{d[7:0]}} : (sz == 2'b01) ? {2{d[15:0]}} : d;
    r.wmask = !st ? 4'b0000 :
              (sz == 2'b00) ? (4'b0001 << a[1:0]) :
              (sz == 2'b01) ? (4'b0011 << a[1:0]) : 4'b1111;
    sh = rdata >> {a[1:0], 3'b000};
    b  = sh[7:0];
    h  = a[1] ? rdata[31:16] : rdata[15:0];
    if (sz == 2'b00)      ld = uns ? {24'b0, b} : {{24{b[7]}}, b};
    else if (sz == 2'b01) ld = uns ? {16'b0, h} : {{16{h[15]}}, h};
    else                  ld = rdata;
    w.tag  = tag;
    w.exc  = mis;
    w.data = (mis || st) ? 32'b0 : ld;
  endfunction

  task automatic push_exp(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdata, input logic [5:0] tag);
    logic mis;
    req_t r;
    wb_t  w;
    model(st, sz, uns, a, d, rdata, tag, mis, r, w);
    if (!mis) reqq.push_back(r);
    wbq.push_back(w);
    cache_rdata = rdata;
    data_i  = {st, sz, uns, a, d, tag, 7'h55};
    valid_i = 1'b1;
  endtask

  task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rdata, input logic [5:0] tag);
    logic acc;
    int   n;
    push_exp(st, sz, uns, a, d, rdata, tag);
    n = 0;
    do begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
    valid_i = 1'b0;
    data_i  = {17'($urandom), $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((reqq.size() != 0 || wbq.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check_val("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compare every presented request/completion against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (dc_req_valid_o) begin
        if (reqq.size() == 0) begin
          check_val("req_unexpected", 32'd1, 32'd0);
        end else begin
          check_val("req_we", 32'(dc_req_we_o), 32'(reqq[0].we));
          check_val("req_addr", dc_req_addr_o, reqq[0].addr);
          check_val("req_wmask", 32'(dc_req_wmask_o), 32'(reqq[0].wmask));
          if (reqq[0].we) check_val("req_wdata", dc_req_wdata_o, reqq[0].wdata);
          check_val("req_ready_o", 32'(ready_o), 32'd0);
          if (dc_req_ready_i) begin
            req_fire = 1'b1;
            $display("req  we=%0d addr=0x%08h mask=%b wdata=0x%08h",
                     dc_req_we_o, dc_req_addr_o, dc_req_wmask_o, dc_req_wdata_o);
            void'(reqq.pop_front());
          end
        end
      end
      if (wb_valid_o) begin
        if (wbq.size() == 0) begin
          check_val("wb_unexpected", 32'd1, 32'd0);
        end else begin
          check_val("wb_tag", 32'(wb_tag_o), 32'(wbq[0].tag));
          check_val("wb_data", wb_data_o, wbq[0].data);
          check_val("wb_exc", 32'(wb_exc_o), 32'(wbq[0].exc));
          check_val("wb_ready_o", 32'(ready_o), 32'd0);
          if (wb_ready_i) begin
            $display("wb   tag=%0d data=0x%08h exc=%0d", wb_tag_o, wb_data_o, wb_exc_o);
            void'(wbq.pop_front());
          end
        end
      end
    end
  end

  // Cache model: single-cycle response pulse resp_delay cycles after the accepting edge
  always @(posedge clk) begin
    #1;
    dc_resp_valid_i = 1'b0;
    if (req_fire) begin
      req_fire = 1'b0;
      if (resp_delay == 0) begin
        dc_resp_valid_i = 1'b1;
        dc_resp_rdata_i = cache_rdata;
      end else begin
        resp_cnt = resp_delay;
      end
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        dc_resp_valid_i = 1'b1;
        dc_resp_rdata_i = cache_rdata;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst             = 1'b1;
    valid_i         = 1'b0;
    data_i          = '0;
    dc_req_ready_i  = 1'b1;
    dc_resp_valid_i = 1'b0;
    dc_resp_rdata_i = 32'b0;
    wb_ready_i      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_val("rst_ready_o", 32'(ready_o), 32'd1);
    check_val("rst_req_valid", 32'(dc_req_valid_o), 32'd0);
    check_val("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check_val("rst_wb_exc", 32'(wb_exc_o), 32'd0);
    check_val("rst_wb_data", wb_data_o, 32'd0);
    check_val("rst_wb_tag", 32'(wb_tag_o), 32'd0);
    check_val("rst_req_addr", dc_req_addr_o, 32'd0);
    check_val("rst_req_wmask", 32'(dc_req_wmask_o), 32'd0);
    check_val("rst_req_wdata", dc_req_wdata_o, 32'd0);

    // Directed accesses
    resp_delay = 1;
    send(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 6'd5);
    drain();
    send(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 6'd1);
    drain();
    send(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 6'd2);
    drain();
    send(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 6'd3);
    drain();
    send(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 6'd4);
    drain();
    send(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 6'd6);
    drain();
    send(1'b0, 2'b10, 1'b1, 32'h0000_0104, 32'h0, 32'h8000_0001, 6'd7);
    drain();
    send(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_5678, 32'h0, 6'd8);
    drain();
    send(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 6'd12);
    drain();

    // Misaligned and illegal-size entries complete the cycle after accept
    send(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 6'd9);
    check_val("mis_wb_valid", 32'(wb_valid_o), 32'd1);
    check_val("mis_wb_exc", 32'(wb_exc_o), 32'd1);
    drain();
    send(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h1, 32'h0, 6'd10);
    check_val("ill_wb_valid", 32'(wb_valid_o), 32'd1);
    check_val("ill_wb_exc", 32'(wb_exc_o), 32'd1);
    drain();
    send(1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h1, 32'h0, 6'd13);
    drain();

    // Minimum latency with an immediately ready cache and next-cycle response
    resp_delay = 0;
    send(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 6'd11);
    @(posedge clk);
    #1;
    check_val("lat_wb_early", 32'(wb_valid_o), 32'd0);
    @(posedge clk);
    #1;
    check_val("lat_wb_on_time", 32'(wb_valid_o), 32'd1);
    drain();

    // Random mix
    for (int i = 0; i < 24; i++) begin
      resp_delay = int'($urandom_range(0, 3));
      send(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
           6'($urandom));
      drain();
    end

    // Backpressure on both handshakes, with a second entry waiting
    resp_delay     = 1;
    dc_req_ready_i = 1'b0;
    wb_ready_i     = 1'b0;
    send(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 6'd20);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("bp_req_valid", 32'(dc_req_valid_o), 32'd1);
      check_val("bp_req_ready_o", 32'(ready_o), 32'd0);
    end
    dc_req_ready_i = 1'b1;
    n = 0;
    while (!wb_valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("bp_wb_reached", 32'(wb_valid_o), 32'd1);
    push_exp(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 6'd21);
    repeat (4) begin
      @(posedge clk);
      #1;
      check_val("bp_wb_valid", 32'(wb_valid_o), 32'd1);
      check_val("bp_wb_ready_o", 32'(ready_o), 32'd0);
    end
    wb_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_idle_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    check_val("bp_second_taken", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    drain();

    // Reset while waiting for a response; the late response must be ignored
    resp_delay = 3;
    send(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'h5555_AAAA, 6'd30);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_wait_ready_o", 32'(ready_o), 32'd1);
    check_val("rst_wait_wb_valid", 32'(wb_valid_o), 32'd0);
    repeat (6) begin
      @(posedge clk);
      #1;
      check_val("stray_wb_valid", 32'(wb_valid_o), 32'd0);
    end
    resp_delay = 1;
    send(1'b0, 2'b00, 1'b0, 32'h0000_0601, 32'h0, 32'h0000_7F00, 6'd31);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsq_dcache_port.md
Name: lsq_dcache_port

Overview:
- Downstream consumer of the LSQ shift queue: takes the head LSQ entry over a valid/ready handshake and performs one data-cache access at a time.
- Loads: byte-lane extraction plus sign or zero extension. Stores: byte write-mask and replicated write data.
- Presents each completion (result or misalignment exception) to writeback/ROB with its tag over a second valid/ready handshake.
- Strictly one entry in flight; this is a blocking, in-order memory port.

Parameters:
ENTRY_WIDTH, 81, LSQ entry width; the fields below are fixed, bits [6:0] are reserved and ignored
TAG_WIDTH, 6, ROB tag width; fixed at 6 by the entry layout

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
valid_i  input  1  LSQ head entry valid
ready_o  output  1  block accepts an entry this cycle
data_i  input  ENTRY_WIDTH  LSQ entry: [80] is_store, [79:78] size (00 byte, 01 half, 10 word, 11 illegal), [77] unsigned-load, [76:45] addr, [44:13] store data, [12:7] rob tag
dc_req_valid_o  output  1  cache request valid
dc_req_ready_i  input  1  cache accepts request
dc_req_we_o  output  1  1 = store
dc_req_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
dc_req_wdata_o  output  32  store data, lane-replicated
dc_req_wmask_o  output  4  byte write enables (0000 for loads)
dc_resp_valid_i  input  1  cache response (load data or store ack), single-cycle pulse
dc_resp_rdata_i  input  32  cache read word
wb_valid_o  output  1  completion valid
wb_ready_i  input  1  writeback accepts completion
wb_tag_o  output  TAG_WIDTH  ROB tag of completion
wb_data_o  output  32  extended load result; 0 for stores and exceptions
wb_exc_o  output  1  misaligned or illegal-size access

Behaviour:
- Clock/reset: one clock clk; rst is synchronous, active-high. On reset: state=IDLE; ready_o=1, dc_req_valid_o=0, wb_valid_o=0, wb_exc_o=0; all data/addr/mask/tag outputs 0.
- FSM states:
  - IDLE: ready_o=1. When valid_i=1, latch the entry into internal registers. Go to WB with wb_exc_o=1 if misaligned (half with addr[0]=1; word with addr[1:0]!=0; size=11). Otherwise go to REQ.
  - REQ: dc_req_valid_o=1; all dc_req_* outputs are held stable. When dc_req_ready_i=1, go to WAIT.
  - WAIT: wait for dc_resp_valid_i. Loads: capture the extended result. Stores: data=0. Then go to WB.
  - WB: wb_valid_o=1; tag/data/exc are held stable. When wb_ready_i=1, go to IDLE.
- ready_o is 1 only in IDLE.
- Minimum latency, accept to wb_valid_o: 3 cycles with dc_req_ready_i already 1 and a next-cycle response. Misaligned: wb_valid_o is 1 the cycle after accept.
- Maximum throughput: one entry every 4 cycles.
- Store mask: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
- Store wdata: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
- Load extraction: byte = rdata lane addr[1:0]; half = rdata half addr[1]; word = whole word. Sign-extend unless unsigned-load=1; the unsigned bit is ignored for word loads.
- dc_resp_valid_i outside WAIT is ignored.
- A response arriving in the same cycle as the REQ->WAIT transition is not accepted; the cache guarantees at least one cycle between request acceptance and response.
- Reset mid-operation from any state: return to IDLE and drop the latched entry. The cache is reset by the same rst, so no stale response is delivered.
- data_i is sampled only on valid_i&&ready_o; changes to data_i at other times have no effect.

Test Plan:
- Word load, addr 0x100, tag 5, dc_req_ready_i=1, response rdata 0xDEADBEEF two cycles after request -> dc_req_addr_o=0x100, wmask 0000; wb_tag_o=5, wb_data_o=0xDEADBEEF, wb_exc_o=0.
- Signed byte load, addr 0x103, rdata 0x80FF_1234 -> wb_data_o=0xFFFFFF80. Same load with unsigned=1 -> 0x00000080.
- Half store, addr 0x202, data 0x0000ABCD -> dc_req_we_o=1, addr 0x200, wmask 1100, wdata 0xABCDABCD; after ack, wb_valid_o with data 0.
- Misaligned word load at 0x101, tag 9 -> no dc_req_valid_o; wb_valid_o next cycle with wb_exc_o=1, tag 9. Size=11 behaves identically.
- Backpressure: dc_req_ready_i low 3 cycles, then wb_ready_i low 4 cycles -> request and completion outputs stable throughout, ready_o=0 until the WB handshake; a second queued entry is accepted the cycle after.
- Assert rst during WAIT, then pulse dc_resp_valid_i -> ready_o=1 and wb_valid_o=0 the cycle after reset; the stray response produces no completion.
